// File: rtl/digit_entry_controller.sv
// Multi-digit decimal operand entry driven by short/long press pulses, with
// serial BCD-to-binary conversion and a valid/ack handoff. Optional: CURSOR_BLINK_EN.
`timescale 1ns/1ps
module digit_entry_controller #(
   parameter int NUM_DIGITS = 4,
   parameter int VALUE_W    = 14,
   parameter int BLINK_HALF = 50
) (
   input  logic                          clk_db,
   input  logic                          rst,
   input  logic                          short_press,
   input  logic                          long_press,
   input  logic                          clear,
   input  logic                          operand_ack,
   output logic [4*NUM_DIGITS-1:0]       digits_bcd,
   output logic [$clog2(NUM_DIGITS)-1:0] cursor,
   output logic [VALUE_W-1:0]            operand,
   output logic                          operand_valid,
   output logic                          busy,
   output logic                          cursor_blink
);

   localparam int CUR_W = $clog2(NUM_DIGITS);
   localparam int IDX_W = $clog2(NUM_DIGITS + 1);

   typedef enum logic [1:0] {ENTRY, CONV, VALID} state_t;
   typedef logic [3:0] digit_t;

   if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("NUM_DIGITS must be in 2..8");
   end
   if ((64'd1 << VALUE_W) < 64'(10 ** NUM_DIGITS)) begin : g_bad_width
      $error("VALUE_W too narrow for NUM_DIGITS decimal digits");
   end
   if (BLINK_HALF < 1) begin : g_bad_blink
      $error("BLINK_HALF must be at least 1");
   end

   state_t             state_q, state_d;
   digit_t             digits_q [NUM_DIGITS];
   digit_t             digits_d [NUM_DIGITS];
   logic [CUR_W-1:0]   cursor_q, cursor_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [VALUE_W-1:0] acc_q, acc_d;
   logic [VALUE_W-1:0] operand_q, operand_d;
   logic               valid_q, valid_d;
   logic               busy_q;
   digit_t             conv_digit;
   logic [VALUE_W-1:0] acc_next;

   // NOTE: the digit file is a handful of flops, not a RAM, so it is reset
   // with everything else; only true memory arrays should skip reset.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_db or posedge rst) begin
      if (rst) begin
         state_q   <= ENTRY;
         digits_q  <= '{default: '0};
         cursor_q  <= '0;
         idx_q     <= '0;
         acc_q     <= '0;
         operand_q <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         cursor_q  <= cursor_d;
         idx_q     <= idx_d;
         acc_q     <= acc_d;
         operand_q <= operand_d;
         valid_q   <= valid_d;
         busy_q    <= (state_d != ENTRY);
      end
   end

   // Multiply-by-ten as shift-and-add, truncated to the operand width.
   always_comb begin
      conv_digit = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) conv_digit = digits_q[i];
      end
      acc_next = (acc_q << 3) + (acc_q << 1) + {{(VALUE_W-4){1'b0}}, conv_digit};
   end

   // NOTE: every target gets a hold-value default up front, so no path
   // through the case leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      digits_d  = digits_q;
      cursor_d  = cursor_q;
      idx_d     = idx_q;
      acc_d     = acc_q;
      operand_d = operand_q;
      valid_d   = valid_q;
      if (clear) begin
         state_d  = ENTRY;
         digits_d = '{default: '0};
         cursor_d = '0;
         valid_d  = 1'b0;
      end else begin
         case (state_q)
            ENTRY: begin
               if (long_press) begin
                  if (cursor_q == CUR_W'(NUM_DIGITS - 1)) begin
                     state_d = CONV;
                     idx_d   = '0;
                     acc_d   = '0;
                  end else begin
                     cursor_d = cursor_q + CUR_W'(1);
                  end
               end else if (short_press) begin
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     if (cursor_q == CUR_W'(i))
                        digits_d[i] = (digits_q[i] == 4'd9) ? 4'd0 : digits_q[i] + 4'd1;
                  end
               end
            end
            CONV: begin
               // One extra cycle after the last digit publishes the result.
               if (idx_q == IDX_W'(NUM_DIGITS)) begin
                  operand_d = acc_q;
                  valid_d   = 1'b1;
                  state_d   = VALID;
               end else begin
                  acc_d = acc_next;
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            VALID: begin
               if (operand_ack) begin
                  valid_d  = 1'b0;
                  digits_d = '{default: '0};
                  cursor_d = '0;
                  state_d  = ENTRY;
               end
            end
            default: state_d = ENTRY;
         endcase
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
         digits_bcd[4*(NUM_DIGITS-1-i) +: 4] = digits_q[i];
      end
      cursor        = cursor_q;
      operand       = operand_q;
      operand_valid = valid_q;
      busy          = busy_q;
   end

`ifdef CURSOR_BLINK_EN
   localparam int CNT_W = $clog2(BLINK_HALF + 1);

   logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic             blink_q, blink_d;

   always_ff @(posedge clk_db or posedge rst) begin
      if (rst) begin
         blink_cnt_q <= '0;
         blink_q     <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         blink_q     <= blink_d;
      end
   end

   // Any user activity or leaving ENTRY restarts the blink with the digit shown.
   always_comb begin
      blink_cnt_d = blink_cnt_q + CNT_W'(1);
      blink_d     = blink_q;
      if (clear || state_q != ENTRY || short_press || long_press) begin
         blink_cnt_d = '0;
         blink_d     = 1'b1;
      end else if (blink_cnt_q == CNT_W'(BLINK_HALF - 1)) begin
         blink_cnt_d = '0;
         blink_d     = ~blink_q;
      end
   end

   assign cursor_blink = blink_q;
`else
   assign cursor_blink = 1'b1;
`endif

endmodule

// File: tb/tb_digit_entry_controller.sv
// Directed bench for digit_entry_controller: entry, wrap, handshake, clear,
// async reset, and the blink option; conversion results go through a scoreboard.
`timescale 1ns/1ps
module tb_digit_entry_controller;

   logic        clk_db = 1'b0;
   logic        rst;
   logic        short_press, long_press, clear, operand_ack;
   logic [15:0] digits_bcd;
   logic [1:0]  cursor;
   logic [13:0] operand;
   logic        operand_valid, busy, cursor_blink;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [13:0] exp_q[$];

   digit_entry_controller #(.NUM_DIGITS(4), .VALUE_W(14), .BLINK_HALF(50)) dut (
      .clk_db(clk_db), .rst(rst), .short_press(short_press), .long_press(long_press),
      .clear(clear), .operand_ack(operand_ack), .digits_bcd(digits_bcd), .cursor(cursor),
      .operand(operand), .operand_valid(operand_valid), .busy(busy), .cursor_blink(cursor_blink)
   );

   always #5 clk_db = ~clk_db;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_db);
      #1;
   endtask

   task automatic press_short(input int n);
      for (int i = 0; i < n; i++) begin
         short_press = 1'b1;
         tick();
         short_press = 1'b0;
         tick();
      end
   endtask

   task automatic press_long();
      long_press = 1'b1;
      tick();
      long_press = 1'b0;
   endtask

   // Keys in all four digits, leaving the final committing long press to commit().
   task automatic enter_digits(input logic [15:0] bcd);
      for (int i = 0; i < 4; i++) begin
         press_short(int'(bcd[15-4*i -: 4]));
         if (i < 3) press_long();
      end
   endtask

   task automatic commit(input logic [15:0] bcd);
      int v;
      v = 0;
      for (int i = 0; i < 4; i++) v = v * 10 + int'(bcd[15-4*i -: 4]);
      exp_q.push_back(14'(v));
      press_long();
   endtask

   task automatic wait_valid(input int exp_edges);
      int n;
      logic [13:0] e;
      n = 0;
      while (!operand_valid && n < 20) begin
         tick();
         n++;
      end
      check("valid_latency", 32'(n), 32'(exp_edges));
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("operand", 32'(operand), 32'(e));
      end else begin
         check("sb_pop", 32'(exp_q.size()), 32'd1);
      end
   endtask

   task automatic check_idle(input string tag, input logic [13:0] exp_operand);
      check({tag, "_digits"}, 32'(digits_bcd), 32'h0);
      check({tag, "_cursor"}, 32'(cursor), 32'd0);
      check({tag, "_valid"}, 32'(operand_valid), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_operand"}, 32'(operand), 32'(exp_operand));
   endtask

   initial begin
      rst = 1'b1;
      short_press = 1'b0;
      long_press  = 1'b0;
      clear       = 1'b0;
      operand_ack = 1'b0;
      #12 rst = 1'b0;
      tick();
      check_idle("reset", 14'd0);
      check("reset_blink", 32'(cursor_blink), 32'd1);

      // Digit wrap on digit 0
      press_short(10);
      check("wrap10_digits", 32'(digits_bcd), 32'h0000);
      press_short(9);
      check("wrap9_digits", 32'(digits_bcd), 32'h9000);
      check("wrap_cursor", 32'(cursor), 32'd0);
      clear = 1'b1; tick(); clear = 1'b0;
      check_idle("clr_wrap", 14'd0);

      // 1,2,3,4 entry and conversion
      enter_digits(16'h1234);
      check("pre_commit_cursor", 32'(cursor), 32'd3);
      commit(16'h1234);
      check("conv_digits", 32'(digits_bcd), 32'h1234);
      check("conv_busy", 32'(busy), 32'd1);
      check("conv_valid", 32'(operand_valid), 32'd0);
      wait_valid(5);
      check("valid_busy", 32'(busy), 32'd1);

      // VALID holds under press noise until acked
      for (int i = 0; i < 20; i++) begin
         short_press = (i % 2 == 0);
         long_press  = (i % 3 == 0);
         tick();
         check("hold_operand", 32'(operand), 32'd1234);
         check("hold_digits", 32'(digits_bcd), 32'h1234);
         check("hold_valid", 32'(operand_valid), 32'd1);
      end
      short_press = 1'b0;
      long_press  = 1'b0;
      operand_ack = 1'b1; tick(); operand_ack = 1'b0;
      check_idle("ack", 14'd1234);

      // Clear mid-entry
      press_short(5); press_long(); press_short(7); press_long();
      check("mid_cursor", 32'(cursor), 32'd2);
      check("mid_digits", 32'(digits_bcd), 32'h5700);
      clear = 1'b1; tick(); clear = 1'b0;
      check_idle("clr_mid", 14'd1234);

      // Simultaneous presses: long wins
      press_short(3);
      short_press = 1'b1; long_press = 1'b1; tick();
      short_press = 1'b0; long_press = 1'b0;
      check("both_cursor", 32'(cursor), 32'd1);
      check("both_digits", 32'(digits_bcd), 32'h3000);
      clear = 1'b1; tick(); clear = 1'b0;

      // Maximum value, then clear+ack together
      enter_digits(16'h9999);
      commit(16'h9999);
      wait_valid(5);
      clear = 1'b1; operand_ack = 1'b1; tick();
      clear = 1'b0; operand_ack = 1'b0;
      check_idle("clr_ack", 14'd9999);

      // Clear during CONV abandons the conversion
      enter_digits(16'h1111);
      commit(16'h1111);
      tick(); tick();
      clear = 1'b1; tick(); clear = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 10; i++) begin
         check("abort_valid", 32'(operand_valid), 32'd0);
         tick();
      end
      check_idle("abort", 14'd9999);

      // Async reset between edges mid-CONV
      enter_digits(16'h2222);
      commit(16'h2222);
      tick();
      check("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      exp_q.delete();
      check_idle("async_rst", 14'd0);
      check("async_rst_blink", 32'(cursor_blink), 32'd1);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("post_rst_valid", 32'(operand_valid), 32'd0);
      end

`ifdef CURSOR_BLINK_EN
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < 49; i++) tick();
      check("blink_49", 32'(cursor_blink), 32'd1);
      tick();
      check("blink_50", 32'(cursor_blink), 32'd0);
      for (int i = 0; i < 49; i++) tick();
      check("blink_99", 32'(cursor_blink), 32'd0);
      tick();
      check("blink_100", 32'(cursor_blink), 32'd1);
      for (int i = 0; i < 50; i++) tick();
      check("blink_150", 32'(cursor_blink), 32'd0);
      short_press = 1'b1; tick(); short_press = 1'b0;
      check("blink_press", 32'(cursor_blink), 32'd1);
`else
      for (int i = 0; i < 60; i++) tick();
      check("blink_tied", 32'(cursor_blink), 32'd1);
      short_press = 1'b1; tick(); short_press = 1'b0;
      check("blink_press", 32'(cursor_blink), 32'd1);
`endif

      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
